// File: rtl/ring_osc_freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// ring_osc_meas_pkg
// Shared definitions for the ring-oscillator frequency meter.
// Contents:
//   meas_state_e    : measurement FSM states (IDLE, ARM, GATE, DONE)
//   DEF_GATE_LOG2   : default gate window length exponent (window = 2^n clk)
//   DEF_COUNT_W     : default width of the edge counter / result
//   DEF_SYNC_STAGES : default depth of the osc_in synchronizer
// ---------------------------------------------------------------------------
package ring_osc_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_DONE = 2'd3
    } meas_state_e;

    localparam int DEF_GATE_LOG2   = 10;
    localparam int DEF_COUNT_W     = 16;
    localparam int DEF_SYNC_STAGES = 2;

endpackage : ring_osc_meas_pkg

// File: rtl/ring_osc_freq_meter_if.sv
// ---------------------------------------------------------------------------
// ring_osc_freq_meter_if
// Control/result bundle between the tile wrapper and the frequency meter.
// Signals:
//   start     : level request, sampled every clk by the meter
//   busy      : meter is arming or inside the gate window
//   done      : one-cycle pulse, count_out/overflow were just updated
//   overflow  : latched result saturated
//   count_out : latched edge count of the last completed window
// Modports:
//   master : wrapper side (drives start, observes results)
//   slave  : meter side
// ---------------------------------------------------------------------------
interface ring_osc_freq_meter_if #(
    parameter int COUNT_W = 16
);
    logic               start;
    logic               busy;
    logic               done;
    logic               overflow;
    logic [COUNT_W-1:0] count_out;

    modport master (
        output start,
        input  busy,
        input  done,
        input  overflow,
        input  count_out
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output overflow,
        output count_out
    );
endinterface : ring_osc_freq_meter_if

// File: rtl/ring_osc_freq_meter_osc_sync_edge.sv
// ---------------------------------------------------------------------------
// osc_sync_edge
// Brings the free-running oscillator into the clk domain and flags its
// rising edges. osc_in goes through SYNC_STAGES flops, then one history
// flop; rise is high for one clk when the synchronized level goes 0->1.
// Inputs toggling faster than clk/2 alias; that is a property of the
// measurement, not something this block tries to detect.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (clears all flops)
//   osc_in : ring-oscillator output, asynchronous to clk
//   rise   : one-cycle rising-edge strobe, clk domain
// ---------------------------------------------------------------------------
module osc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic osc_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   hist_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            hist_p1 <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], osc_in};
            hist_p1 <= sync_p0[SYNC_STAGES-1];
        end
    end

    assign rise = sync_p0[SYNC_STAGES-1] & ~hist_p1;

endmodule : osc_sync_edge

// File: rtl/ring_osc_freq_meter.sv
// ---------------------------------------------------------------------------
// ring_osc_freq_meter
// Counts rising edges of the ring oscillator over a gate window of
// 2^GATE_LOG2 clk cycles and latches the count for the tile wrapper.
//
// Timeline: start sampled high in IDLE at cycle T -> ARM at T+1 ->
// GATE at T+2 .. T+1+2^GATE_LOG2 -> DONE (done pulse, new result visible)
// at T+2+2^GATE_LOG2.
//
// Build option: define RING_OSC_FREQ_CONTINUOUS_EN to let DONE go straight
// to ARM while start is high (free-running measurements, 2-cycle gap).
// Without it DONE always returns to IDLE.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   osc_in: ring-oscillator output, asynchronous to clk
//   meas  : slave side of ring_osc_freq_meter_if
//           (start in; busy, done, overflow, count_out out)
// ---------------------------------------------------------------------------
module ring_osc_freq_meter
    import ring_osc_meas_pkg::*;
#(
    parameter int GATE_LOG2   = DEF_GATE_LOG2,
    parameter int COUNT_W     = DEF_COUNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  osc_in,
    ring_osc_freq_meter_if.slave  meas
);

    // Saturating increment. The MSB of the result reports that an edge had
    // to be dropped because the counter was already all-ones.
    function automatic logic [COUNT_W:0] sat_inc(
        input logic [COUNT_W-1:0] cnt,
        input logic               inc
    );
        if (!inc)
            return {1'b0, cnt};
        if (&cnt)
            return {1'b1, cnt};
        return {1'b0, cnt + 1'b1};
    endfunction

    meas_state_e            state_q;
    meas_state_e            state_d;
    logic                   rise;
    logic [GATE_LOG2-1:0]   gate_cnt_q;
    logic                   gate_last;
    logic [COUNT_W-1:0]     edge_cnt_q;
    logic [COUNT_W-1:0]     edge_nxt;
    logic                   edge_lost;
    logic                   sat_q;
    logic                   sat_nxt;
    logic [COUNT_W-1:0]     count_q;
    logic                   ovf_q;
    logic                   busy_c;
    logic                   done_c;

    osc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .osc_in (osc_in),
        .rise   (rise)
    );

    assign gate_last          = &gate_cnt_q;
    assign {edge_lost, edge_nxt} = sat_inc(edge_cnt_q, rise);
    assign sat_nxt            = sat_q | edge_lost;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (meas.start) state_d = ST_ARM;
            ST_ARM:  state_d = ST_GATE;
            ST_GATE: if (gate_last) state_d = ST_DONE;
            ST_DONE: begin
`ifdef RING_OSC_FREQ_CONTINUOUS_EN
                state_d = meas.start ? ST_ARM : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    // FSM outputs: busy and done decode disjoint states, so they never
    // overlap.
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        unique case (state_q)
            ST_ARM, ST_GATE: busy_c = 1'b1;
            ST_DONE:         done_c = 1'b1;
            default:         ;
        endcase
    end

    // Gate window counting. The result is loaded on the last GATE cycle
    // (including an edge arriving on that cycle) so it is already valid
    // while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (state_q == ST_ARM) begin
                gate_cnt_q <= '0;
                edge_cnt_q <= '0;
                sat_q      <= 1'b0;
            end else if (state_q == ST_GATE) begin
                gate_cnt_q <= gate_cnt_q + 1'b1;
                edge_cnt_q <= edge_nxt;
                sat_q      <= sat_nxt;
                if (gate_last) begin
                    count_q <= edge_nxt;
                    ovf_q   <= sat_nxt;
                end
            end
        end
    end

    assign meas.busy      = busy_c;
    assign meas.done      = done_c;
    assign meas.overflow  = ovf_q;
    assign meas.count_out = count_q;

endmodule : ring_osc_freq_meter
